// File: rtl/alu_pkg.sv
// Shared encodings, instruction field positions and legality check for the ALU operand stage.
// Optional feature macro used by the stage: ALU_OPERAND_BYPASS_EN.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_OR  = 4'd3,
        OP_AND = 4'd4,
        OP_XOR = 4'd5
    } alu_op_e;

    typedef enum logic [2:0] {
        SH_NONE = 3'd0,
        SH_SHR  = 3'd1,
        SH_SHL  = 3'd2,
        SH_ROR  = 3'd3
    } alu_shift_e;

    localparam int OP_MSB      = 27;
    localparam int OP_LSB      = 24;
    localparam int RD_MSB      = 23;
    localparam int RD_LSB      = 20;
    localparam int RS1_MSB     = 19;
    localparam int RS1_LSB     = 16;
    localparam int RS2_MSB     = 15;
    localparam int RS2_LSB     = 12;
    localparam int IMM_MSB     = 11;
    localparam int IMM_LSB     = 4;
    localparam int IMM_SEL_BIT = 3;
    localparam int SH_MSB      = 2;
    localparam int SH_LSB      = 0;

    localparam logic [3:0] OP_LAST = OP_XOR;
    localparam logic [2:0] SH_LAST = SH_ROR;

    function automatic logic is_legal(input logic [31:0] instr);
        logic [3:0] op;
        logic [2:0] sh;
        op = instr[OP_MSB:OP_LSB];
        sh = instr[SH_MSB:SH_LSB];
        return (op <= OP_LAST) && (sh <= SH_LAST);
    endfunction

endpackage

// File: rtl/alu_scoreboard.sv
// Per-register pending bits and the issue hazard check for the ALU operand stage.
// With ALU_OPERAND_BYPASS_EN a register being written back this cycle no longer blocks issue.
module alu_scoreboard
    import alu_pkg::*;
#(
    parameter int NREGS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       chk_valid,
    input  logic [3:0] rs1,
    input  logic [3:0] rs2,
    input  logic [3:0] rd,
    input  logic       imm_sel,
    input  logic       set_en,
    input  logic       wb_en,
    input  logic [3:0] wb_addr,
    output logic       hazard
);

    localparam int AW = $clog2(NREGS);

    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;
    logic [NREGS-1:0] clr_s;
    logic [NREGS-1:0] set_s;
    logic [NREGS-1:0] busy_s;

    // Pending update: the set is applied after the clear so a new issue to the same rd wins.
    always_comb begin
        clr_s = {NREGS{1'b0}};
        set_s = {NREGS{1'b0}};
        if (wb_en) begin
            clr_s[wb_addr[AW-1:0]] = 1'b1;
        end else begin
            clr_s = {NREGS{1'b0}};
        end
        if (set_en && (rd != 4'd0)) begin
            set_s[rd[AW-1:0]] = 1'b1;
        end else begin
            set_s = {NREGS{1'b0}};
        end
        pend_d    = (pend_q & ~clr_s) | set_s;
        pend_d[0] = 1'b0;
    end

`ifdef ALU_OPERAND_BYPASS_EN
    assign busy_s = pend_q & ~clr_s;
`else
    assign busy_s = pend_q;
`endif

    assign hazard = chk_valid & (busy_s[rs1[AW-1:0]]
                               | (~imm_sel & busy_s[rs2[AW-1:0]])
                               | busy_s[rd[AW-1:0]]);

    // Pending-bit register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= {NREGS{1'b0}};
        end else begin
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Issue stage in front of the combinational ALU: decode, register-file read, RAW/WAW interlock.
// Define ALU_OPERAND_BYPASS_EN to forward writeback data and issue in the writeback cycle.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [31:0]     alu_instr,
    output logic [3:0]      out_rd,
    input  logic            wb_en,
    input  logic [3:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            err_illegal
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    logic [3:0]      rd_s;
    logic [3:0]      rs1_s;
    logic [3:0]      rs2_s;
    logic [7:0]      imm8_s;
    logic            imm_sel_s;
    logic            legal_s;
    logic            hazard_s;
    logic            accept_s;
    logic            issue_s;
    logic            fwd_a_s;
    logic            fwd_b_s;
    logic [XLEN-1:0] op_a_s;
    logic [XLEN-1:0] op_b_s;

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] alu_in1_q, alu_in1_d;
    logic [XLEN-1:0] alu_in2_q, alu_in2_d;
    logic [31:0]     alu_instr_q, alu_instr_d;
    logic [3:0]      out_rd_q, out_rd_d;
    logic            err_q, err_d;

    assign rd_s      = in_instr[RD_MSB:RD_LSB];
    assign rs1_s     = in_instr[RS1_MSB:RS1_LSB];
    assign rs2_s     = in_instr[RS2_MSB:RS2_LSB];
    assign imm8_s    = in_instr[IMM_MSB:IMM_LSB];
    assign imm_sel_s = in_instr[IMM_SEL_BIT];
    assign legal_s   = is_legal(in_instr);

    alu_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .chk_valid (in_valid & legal_s),
        .rs1       (rs1_s),
        .rs2       (rs2_s),
        .rd        (rd_s),
        .imm_sel   (imm_sel_s),
        .set_en    (issue_s),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .hazard    (hazard_s)
    );

    // Illegal words are accepted under the same output-slot rule but never issue.
    assign in_ready = ~hazard_s & (~out_valid_q | out_ready);
    assign accept_s = in_valid & in_ready;
    assign issue_s  = accept_s & legal_s;

`ifdef ALU_OPERAND_BYPASS_EN
    assign fwd_a_s = wb_en & (wb_addr == rs1_s);
    assign fwd_b_s = wb_en & (wb_addr == rs2_s);
`else
    assign fwd_a_s = 1'b0;
    assign fwd_b_s = 1'b0;
`endif

    // Operand read: R0 is hard zero, operand B may be the zero-extended immediate.
    always_comb begin
        op_a_s = {XLEN{1'b0}};
        op_b_s = {XLEN{1'b0}};
        if (rs1_s == 4'd0) begin
            op_a_s = {XLEN{1'b0}};
        end else if (fwd_a_s) begin
            op_a_s = wb_data;
        end else begin
            op_a_s = regs_q[rs1_s[AW-1:0]];
        end
        if (imm_sel_s) begin
            op_b_s = {{(XLEN-8){1'b0}}, imm8_s};
        end else if (rs2_s == 4'd0) begin
            op_b_s = {XLEN{1'b0}};
        end else if (fwd_b_s) begin
            op_b_s = wb_data;
        end else begin
            op_b_s = regs_q[rs2_s[AW-1:0]];
        end
    end

    // Register-file next state: writeback lands at the clock edge, R0 never changes.
    always_comb begin
        regs_d = regs_q;
        if (wb_en && (wb_addr != 4'd0)) begin
            regs_d[wb_addr[AW-1:0]] = wb_data;
        end else begin
            regs_d[0] = {XLEN{1'b0}};
        end
    end

    // Output slot: load on issue, hold while stalled, empty after a consume.
    always_comb begin
        out_valid_d = out_valid_q;
        alu_in1_d   = alu_in1_q;
        alu_in2_d   = alu_in2_q;
        alu_instr_d = alu_instr_q;
        out_rd_d    = out_rd_q;
        err_d       = err_q;
        if (issue_s) begin
            out_valid_d = 1'b1;
            alu_in1_d   = op_a_s;
            alu_in2_d   = op_b_s;
            alu_instr_d = in_instr;
            out_rd_d    = rd_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (accept_s && !legal_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            alu_in1_q   <= {XLEN{1'b0}};
            alu_in2_q   <= {XLEN{1'b0}};
            alu_instr_q <= 32'd0;
            out_rd_q    <= 4'd0;
            err_q       <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {XLEN{1'b0}};
            end
        end else begin
            out_valid_q <= out_valid_d;
            alu_in1_q   <= alu_in1_d;
            alu_in2_q   <= alu_in2_d;
            alu_instr_q <= alu_instr_d;
            out_rd_q    <= out_rd_d;
            err_q       <= err_d;
            regs_q      <= regs_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign alu_in1     = alu_in1_q;
    assign alu_in2     = alu_in2_q;
    assign alu_instr   = alu_instr_q;
    assign out_rd      = out_rd_q;
    assign err_illegal = err_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomized scoreboard bench for alu_operand_stage against an array/queue reference model.
module tb_alu_operand_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_in1;
    logic [XLEN-1:0] alu_in2;
    logic [31:0]     alu_instr;
    logic [3:0]      out_rd;
    logic            wb_en;
    logic [3:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            err_illegal;

    always #5 clk = ~clk;

    alu_operand_stage #(.NREGS(16), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_instr(alu_instr), .out_rd(out_rd), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .err_illegal(err_illegal)
    );

    typedef struct {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] instr;
        logic [3:0]  rd;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_err = 0;
    logic [31:0] m_regs[16];
    bit          m_pend[16];
    bit          m_busy;
    bit          m_err;
    bit          rand_ready = 1'b0;
    bit          rand_wb = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int op, input int rd, input int rs1, input int rs2,
                                       input int imm, input int isel, input int sh);
        return {4'd0, 4'(op), 4'(rd), 4'(rs1), 4'(rs2), 8'(imm), 1'(isel), 3'(sh)};
    endfunction

    // Reference read: register 0 is zero; bypass builds see this cycle's writeback.
    function automatic logic [31:0] m_read(input logic [3:0] r);
        if (r == 4'd0) return 32'd0;
`ifdef ALU_OPERAND_BYPASS_EN
        if (wb_en && wb_addr == r) return wb_data;
`endif
        return m_regs[r];
    endfunction

    function automatic bit m_blocked(input logic [3:0] r);
`ifdef ALU_OPERAND_BYPASS_EN
        return m_pend[r] && !(wb_en && wb_addr == r);
`else
        return m_pend[r];
`endif
    endfunction

    // Reference model: predicts in_ready/out_valid/err and queues the expected issue.
    always @(negedge clk) begin
        if (rst) begin
            for (int r = 0; r < 16; r++) begin
                m_regs[r] = 32'd0;
                m_pend[r] = 1'b0;
            end
            m_busy = 1'b0;
            m_err  = 1'b0;
            exp_q.delete();
        end else begin
            logic [3:0] op, rd, rs1, rs2;
            logic [2:0] sh;
            bit legal, isel, haz, exp_ready, issue;
            exp_t e;
            op   = in_instr[27:24];
            rd   = in_instr[23:20];
            rs1  = in_instr[19:16];
            rs2  = in_instr[15:12];
            isel = in_instr[3];
            sh   = in_instr[2:0];
            legal = (op <= 4'd5) && (sh <= 3'd3);
            haz = in_valid && legal &&
                  (m_blocked(rs1) || (!isel && m_blocked(rs2)) || m_blocked(rd));
            exp_ready = !haz && (!m_busy || out_ready);
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_busy});
            chk("err_illegal", {31'd0, err_illegal}, {31'd0, m_err});
            if (in_valid) chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
            issue = in_valid && exp_ready && legal;
            if (issue) begin
                e.in1   = m_read(rs1);
                e.in2   = isel ? {24'd0, in_instr[11:4]} : m_read(rs2);
                e.instr = in_instr;
                e.rd    = rd;
                exp_q.push_back(e);
            end
            if (in_valid && exp_ready && !legal) m_err = 1'b1;
            m_busy = issue || (m_busy && !out_ready);
            if (wb_en) begin
                if (wb_addr != 4'd0) m_regs[wb_addr] = wb_data;
                m_pend[wb_addr] = 1'b0;
            end
            if (issue && rd != 4'd0) m_pend[rd] = 1'b1;
        end
    end

    // Monitor: every presented output must match the oldest expected issue.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL out_unexpected: actual=out_valid=1 required=no pending issue");
            end else begin
                chk("alu_in1", alu_in1, exp_q[0].in1);
                chk("alu_in2", alu_in2, exp_q[0].in2);
                chk("alu_instr", alu_instr, exp_q[0].instr);
                chk("out_rd", {28'd0, out_rd}, {28'd0, exp_q[0].rd});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wb(input logic [3:0] a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        step();
        wb_en = 1'b0;
    endtask

    task automatic random_wb();
        int cand[$];
        for (int r = 1; r < 16; r++) if (m_pend[r]) cand.push_back(r);
        wb_en   = ($urandom_range(0, 2) != 0);
        wb_data = $urandom;
        if (cand.size() > 0 && $urandom_range(0, 1) == 1)
            wb_addr = 4'(cand[$urandom_range(0, cand.size() - 1)]);
        else
            wb_addr = 4'($urandom_range(0, 7));
    endtask

    // Offer one instruction until accepted; optionally writeback at loop iteration wb_at.
    task automatic send(input logic [31:0] instr, input int wb_at,
                        input logic [3:0] wa, input logic [31:0] wd);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_instr = instr;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            if (wb_at >= 0) begin
                wb_en = (i == wb_at); wb_addr = wa; wb_data = wd;
            end else if (rand_wb) begin
                random_wb();
            end
            @(negedge clk);
            ok = in_ready;
            step();
        end
        in_valid = 1'b0;
        wb_en    = 1'b0;
        if (!ok) begin
            n_checks++;
            n_err++;
            $display("FAIL accept_timeout: actual=not accepted required=accepted instr=%h", instr);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b1;
        wb_en = 1'b0; wb_addr = 4'd0; wb_data = 32'd0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_alu_in1", alu_in1, 32'd0);
        chk("rst_alu_in2", alu_in2, 32'd0);
        chk("rst_alu_instr", alu_instr, 32'd0);
        chk("rst_out_rd", {28'd0, out_rd}, 32'd0);
        step();

        do_wb(4'd1, 32'd7);
        do_wb(4'd2, 32'd5);
        send(mk(0, 3, 1, 2, 0, 0, 0), -1, 4'd0, 32'd0);
        send(mk(0, 4, 0, 3, 8'hFF, 1, 0), -1, 4'd0, 32'd0);
        send(mk(2, 5, 3, 0, 0, 1, 1), 3, 4'd3, 32'd12);
        repeat (2) step();

        out_ready = 1'b0;
        send(mk(1, 6, 1, 2, 0, 0, 1), -1, 4'd0, 32'd0);
        in_valid = 1'b1;
        in_instr = mk(3, 7, 1, 2, 0, 0, 2);
        repeat (4) step();
        out_ready = 1'b1;
        send(mk(3, 7, 1, 2, 0, 0, 2), -1, 4'd0, 32'd0);
        step();

        send(mk(6, 8, 1, 2, 0, 0, 0), -1, 4'd0, 32'd0);
        send(mk(0, 9, 1, 2, 0, 0, 5), -1, 4'd0, 32'd0);
        repeat (3) step();

        out_ready = 1'b0;
        send(mk(0, 3, 1, 2, 0, 0, 0), -1, 4'd0, 32'd0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        send(mk(4, 8, 3, 3, 0, 0, 3), -1, 4'd0, 32'd0);
        step();

        rand_ready = 1'b1;
        rand_wb    = 1'b1;
        for (int n = 0; n < 150; n++) begin
            int op, sh;
            op = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 15) : $urandom_range(0, 5);
            sh = ($urandom_range(0, 19) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
            send(mk(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 255), $urandom_range(0, 1), sh), -1, 4'd0, 32'd0);
        end
        rand_ready = 1'b0;
        rand_wb    = 1'b0;
        out_ready  = 1'b1;
        repeat (4) step();
        chk("drain", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
